// File: rtl/dm_port_seq_if.sv
// Requester and memory-side signals around the data-memory port sequencer.
// master: the sequencer's view; slave: the two requesters plus the memory.
interface dm_port_seq_if;
  logic        p_req;
  logic        p_we;
  logic        p_is64;
  logic [31:0] p_addr;
  logic [3:0]  p_sel;
  logic [63:0] p_wdata;
  logic [63:0] p_rdata;
  logic        p_done;
  logic        p_err;

  logic        x_req;
  logic        x_we;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [31:0] x_rdata;
  logic        x_done;
  logic        x_err;

  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  p_req, p_we, p_is64, p_addr, p_sel, p_wdata,
    output p_rdata, p_done, p_err,
    input  x_req, x_we, x_addr, x_wdata,
    output x_rdata, x_done, x_err,
    output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output p_req, p_we, p_is64, p_addr, p_sel, p_wdata,
    input  p_rdata, p_done, p_err,
    output x_req, x_we, x_addr, x_wdata,
    input  x_rdata, x_done, x_err,
    input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dm_port_seq.sv
// Sequencer/arbiter for the single 32-bit data-memory port. The exception unit has fixed priority
// over the pipeline; 64-bit transfers run as low beat then high beat; each beat is bounded by a
// wait counter and aborts with an error flag when memory never acknowledges.
module dm_port_seq #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  dm_port_seq_if.master bus,
  output logic          stall_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {StIdle, StAccLo, StAccHi, StResp} state_e;

  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);

  state_e           state_q,   state_d;
  logic             gnt_x_q,   gnt_x_d;
  logic             we_q,      we_d;
  logic             is64_q,    is64_d;
  logic [29:0]      waddr_q,   waddr_d;
  logic [3:0]       sel_q,     sel_d;
  logic [63:0]      wdata_q,   wdata_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      lo_q,      lo_d;
  logic [63:0]      p_rdata_q, p_rdata_d;
  logic [31:0]      x_rdata_q, x_rdata_d;
  logic             p_done_q,  p_done_d;
  logic             p_err_q,   p_err_d;
  logic             x_done_q,  x_done_d;
  logic             x_err_q,   x_err_d;

  logic        fin;
  logic        fin_err;
  logic [31:0] fin_lo;
  logic [31:0] fin_hi;

  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;

  // Memory is always word-addressed; byte offsets only matter through p_sel.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{bus.p_addr[1:0], bus.x_addr[1:0]};

  // Next-state: arbitration, beat sequencing, wait counter and response capture.
  always_comb begin
    state_d   = state_q;
    gnt_x_d   = gnt_x_q;
    we_d      = we_q;
    is64_d    = is64_q;
    waddr_d   = waddr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    p_rdata_d = p_rdata_q;
    x_rdata_d = x_rdata_q;
    p_done_d  = 1'b0;
    p_err_d   = 1'b0;
    x_done_d  = 1'b0;
    x_err_d   = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_lo    = lo_q;
    fin_hi    = bus.mem_rdata;

    case (state_q)
      StIdle: begin
        if (bus.x_req) begin
          gnt_x_d = 1'b1;
          we_d    = bus.x_we;
          is64_d  = 1'b0;
          waddr_d = bus.x_addr[31:2];
          sel_d   = 4'hF;
          wdata_d = {32'h0, bus.x_wdata};
          cnt_d   = '0;
          state_d = StAccLo;
        end else if (bus.p_req) begin
          gnt_x_d = 1'b0;
          we_d    = bus.p_we;
          is64_d  = bus.p_is64;
          waddr_d = bus.p_addr[31:2];
          sel_d   = bus.p_is64 ? 4'hF : bus.p_sel;
          wdata_d = bus.p_wdata;
          cnt_d   = '0;
          state_d = StAccLo;
        end
      end
      StAccLo: begin
        if (bus.mem_ack) begin
          lo_d  = bus.mem_rdata;
          cnt_d = '0;
          if (is64_q) begin
            state_d = StAccHi;
          end else begin
            fin    = 1'b1;
            fin_lo = bus.mem_rdata;
          end
        end else if (cnt_q == CntLimit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAccHi: begin
        if (bus.mem_ack) begin
          fin = 1'b1;
        end else if (cnt_q == CntLimit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Completion: the response goes only to the granted requester; errors and writes read as 0.
    if (fin) begin
      state_d = StResp;
      if (gnt_x_q) begin
        x_done_d  = 1'b1;
        x_err_d   = fin_err;
        x_rdata_d = (fin_err || we_q) ? 32'h0 : fin_lo;
      end else begin
        p_done_d  = 1'b1;
        p_err_d   = fin_err;
        p_rdata_d = (fin_err || we_q) ? 64'h0 :
                    (is64_q ? {fin_hi, fin_lo} : {32'h0, fin_lo});
      end
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_x_q   <= 1'b0;
      we_q      <= 1'b0;
      is64_q    <= 1'b0;
      waddr_q   <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      lo_q      <= '0;
      p_rdata_q <= '0;
      x_rdata_q <= '0;
      p_done_q  <= 1'b0;
      p_err_q   <= 1'b0;
      x_done_q  <= 1'b0;
      x_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_x_q   <= gnt_x_d;
      we_q      <= we_d;
      is64_q    <= is64_d;
      waddr_q   <= waddr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      p_rdata_q <= p_rdata_d;
      x_rdata_q <= x_rdata_d;
      p_done_q  <= p_done_d;
      p_err_q   <= p_err_d;
      x_done_q  <= x_done_d;
      x_err_q   <= x_err_d;
    end
  end

  // Memory port decoded from registered state only, so it is stable for the whole beat.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_sel   = 4'h0;
    mem_wdata = 32'h0;
    if (state_q == StAccLo) begin
      mem_ce    = 1'b1;
      mem_we    = we_q;
      mem_addr  = {waddr_q, 2'b00};
      mem_sel   = sel_q;
      mem_wdata = wdata_q[31:0];
    end else if (state_q == StAccHi) begin
      mem_ce    = 1'b1;
      mem_we    = we_q;
      mem_addr  = {waddr_q + 30'd1, 2'b00};
      mem_sel   = 4'hF;
      mem_wdata = wdata_q[63:32];
    end
  end

  assign bus.mem_ce    = mem_ce;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_sel   = mem_sel;
  assign bus.mem_wdata = mem_wdata;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.p_done    = p_done_q;
  assign bus.p_err     = p_err_q;
  assign bus.x_rdata   = x_rdata_q;
  assign bus.x_done    = x_done_q;
  assign bus.x_err     = x_err_q;

  assign stall_o = bus.p_req & ~p_done_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: doc/dm_port_seq.md
Name: dm_port_seq

Overview:
- Sequencer and arbiter for the single 32-bit data-memory port.
- Shares the port between two requesters:
  - the MEM-stage pipeline requester (push/pop/call/ret/leave and the 64-bit descriptor-table loads/stores)
  - the exception-entry requester (return-address pushes).
- Splits 64-bit transfers into two 32-bit beats.
- Tolerates wait-state memory and enforces an acknowledge timeout.
- Drives a pipeline stall while a pipeline access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles a beat may wait for mem_ack before aborting with error (2..255)
- CNT_W, 8, width of the wait counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- p_req  in  1  pipeline request; held high until p_done
- p_we  in  1  pipeline write (1) / read (0)
- p_is64  in  1  64-bit (two-beat) transfer
- p_addr  in  32  pipeline byte address
- p_sel  in  4  byte selects for 32-bit transfers
- p_wdata  in  64  write data; [31:0] is the low beat
- p_rdata  out  64  read data, valid with p_done
- p_done  out  1  one-cycle completion pulse
- p_err  out  1  timeout flag, valid with p_done
- x_req  in  1  exception-unit request; held until x_done
- x_we  in  1  exception write/read
- x_addr  in  32  exception byte address
- x_wdata  in  32  exception write data
- x_rdata  out  32  exception read data, valid with x_done
- x_done  out  1  one-cycle completion pulse
- x_err  out  1  timeout flag, valid with x_done
- stall_o  out  1  pipeline stall request
- busy_o  out  1  sequencer not in IDLE
- mem_ce  out  1  memory chip enable / beat request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned memory address
- mem_sel  out  4  byte selects
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  beat complete

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output 0, including the p_rdata/x_rdata registers, the grant register and the wait counter. Reset mid-beat drops mem_ce immediately; the transfer is lost and no done pulse is issued.
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE arbitration:
  - Fixed priority: x_req wins over p_req.
  - The winner's request fields are latched on the clock edge and the state moves to ACC_LO.
  - The x requester is always treated as 32-bit, we=x_we, sel=4'b1111.
- ACC_LO:
  - mem_ce=1, mem_addr={addr[31:2],2'b00}, mem_we=latched we.
  - mem_sel = p_sel for a 32-bit pipeline transfer; 4'b1111 otherwise.
  - mem_wdata = low word.
  - On mem_ack: capture mem_rdata into the low read word; go to ACC_HI if is64, else RESP.
- ACC_HI:
  - mem_addr = {addr[31:2],2'b00} + 4, wrapping modulo 2^32.
  - mem_wdata = high word; mem_sel = 4'b1111.
  - On mem_ack: capture the high read word, go to RESP.
- Outputs remain stable throughout a beat until mem_ack. mem_ce is 0 in IDLE and RESP.
- Wait counter:
  - Clears on entry to each ACC state and increments each cycle without mem_ack.
  - If the counter reaches TIMEOUT-1 with no ack: abort the transfer (no second beat), set err, zero the read data, go to RESP.
  - mem_ack in the same cycle as the limit counts as success.
- RESP:
  - Pulse done/err for exactly one cycle to the granted requester only, then return to IDLE.
  - Requests are not sampled in RESP. The requester must deassert req the cycle after done. Any still-pending request is arbitrated in the following IDLE cycle, so there is 1 bubble cycle between back-to-back transfers.
- Read data:
  - 32-bit pipeline read: p_rdata = {32'h0, word}.
  - Write transfers return p_rdata = 0.
  - Read registers hold their value until the next done for that requester.
- Latency with zero-wait memory (req seen in IDLE at cycle 0): 32-bit done at cycle 2; 64-bit done at cycle 3. Each wait state adds 1 cycle.
- stall_o = p_req & ~p_done, combinational. It asserts in the same cycle as p_req, including while x holds the port.
- busy_o = (state != IDLE).
- p_req and x_req asserted in the same cycle: x is served first; p is served after x_done plus 1 cycle, with stall held throughout.

Test Plan:
1. 32-bit pipeline write, p_addr=0x1003, p_sel=4'b0011, wdata[31:0]=0xDEADBEEF, ack immediate -> one beat: mem_addr=0x1000, mem_sel=0011, mem_we=1; p_done at cycle 2; p_err=0; stall_o high cycles 0-1, low at cycle 2.
2. 64-bit read at p_addr=0x2000 (LGDT-style), mem_rdata 0x11111111 then 0x22222222, 1 wait state per beat -> beats at 0x2000 then 0x2004; p_rdata=0x2222222211111111; p_done at cycle 5.
3. 64-bit write at p_addr=0xFFFFFFFC -> second beat mem_addr=0x00000000 (wrap); beat order low then high; mem_sel=1111 on both beats.
4. p_req and x_req raised together; x writes 0x0000ABCD to 0x3FFC -> x served first (x_done), 1 idle cycle, then the pipeline transfer; no p_done during the x transfer; stall_o high throughout.
5. TIMEOUT=16, mem_ack held low on a 32-bit read -> p_done and p_err=1 exactly 16 cycles after ACC_LO entry; p_rdata=0; a subsequent transfer with ack completes normally with err=0.
6. rst pulsed low during ACC_HI of a 64-bit read -> mem_ce, busy_o and all done/err outputs 0 immediately; state IDLE after release; a new request is granted normally.
